// File: rtl/arm_imm_encoder_pkg.sv
// Shared types and widths for the ARM rotated-immediate encoder slice.
// Defines the encoder FSM states and the {rotate_imm, immed_8} field geometry.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } enc_state_t;

  localparam int ENC_W = 12;
  localparam int ROT_W = 4;
  localparam int IMM_W = 8;

  // Field layout consumed by the instruction builder: rotate_imm in the top nibble.
  function automatic logic [ENC_W-1:0] pack_enc(input logic [ROT_W-1:0] rot,
                                                input logic [IMM_W-1:0] imm);
    return {rot, imm};
  endfunction

endpackage

// File: rtl/arm_imm_encoder_if.sv
// Request/result bundle of the rotated-immediate encoder.
// master = requester (instruction builder / bench), slave = encoder.
interface arm_imm_encoder_if;
  import arm_pkg::*;

  logic             start;
  logic [31:0]      value;
  logic             busy;
  logic             done;
  logic             found;
  logic [ENC_W-1:0] enc;
  logic             inv;

  modport master (
    output start, value,
    input  busy, done, found, enc, inv
  );

  modport slave (
    input  start, value,
    output busy, done, found, enc, inv
  );

endinterface

// File: rtl/arm_imm_encoder_rol_even.sv
// Combinational rotate-left of a 32-bit word by an even amount 2*rot (0..30).
// Inverse of the shifter's ROR(immed_8, 2*rotate_imm) decode.
module rol_even
  import arm_pkg::*;
(
  input  logic [31:0]      din,
  input  logic [ROT_W-1:0] rot,
  output logic [31:0]      dout
);

  logic [5:0] amt;

  assign amt = {1'b0, rot, 1'b0};

  // A right shift by 32 (amt == 0) yields zero, so rot 0 passes din through unchanged.
  assign dout = (din << amt) | (din >> (6'd32 - amt));

endmodule

// File: rtl/arm_imm_encoder.sv
// Sequential ARM rotated-immediate encoder: tries one even rotation per cycle, lowest first.
// Optional macro ARM_IMM_ENC_INV_EN adds the inverted (MVN/BIC) candidate per rotation.
module arm_imm_encoder
  import arm_pkg::*;
#(
  parameter int ROT_LIMIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  arm_imm_encoder_if.slave    bus
);

  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_LIMIT - 1);

  enc_state_t       state_q, state_d;
  logic [ROT_W-1:0] rot_q;
  logic [31:0]      val_q;
  logic             found_q;
  logic [ENC_W-1:0] enc_q;
  logic             inv_q;

  logic [31:0]      cand;
  logic             hit;
  logic [IMM_W-1:0] hit_imm;
  logic             hit_inv;
  logic             last_rot;
  logic             busy;
  logic             done;

  rol_even u_rol (
    .din  (val_q),
    .rot  (rot_q),
    .dout (cand)
  );

`ifdef ARM_IMM_ENC_INV_EN
  logic [31:0] val_n;
  logic [31:0] candi;

  assign val_n = ~val_q;

  rol_even u_rol_inv (
    .din  (val_n),
    .rot  (rot_q),
    .dout (candi)
  );
`endif

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    hit     = (cand[31:IMM_W] == '0);
    hit_imm = cand[IMM_W-1:0];
    hit_inv = 1'b0;
`ifdef ARM_IMM_ENC_INV_EN
    // Direct form wins at equal rotation; the inverted form only fills the gap.
    if (!hit && (candi[31:IMM_W] == '0)) begin
      hit     = 1'b1;
      hit_imm = candi[IMM_W-1:0];
      hit_inv = 1'b1;
    end
`endif
  end

  assign last_rot = (rot_q == ROT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)         state_d = SEARCH;
      SEARCH:  if (hit || last_rot)   state_d = DONE;
      DONE:                           state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SEARCH);
    done = (state_q == DONE);
  end

  // Rotation counter, latched operand and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rot_q   <= '0;
      val_q   <= '0;
      found_q <= 1'b0;
      enc_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            val_q   <= bus.value;
            rot_q   <= '0;
            found_q <= 1'b0;
            enc_q   <= '0;
            inv_q   <= 1'b0;
          end
        end
        SEARCH: begin
          if (hit) begin
            found_q <= 1'b1;
            enc_q   <= pack_enc(rot_q, hit_imm);
            inv_q   <= hit_inv;
          end else if (!last_rot) begin
            rot_q   <= rot_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.found = found_q;
  assign bus.enc   = enc_q;
`ifdef ARM_IMM_ENC_INV_EN
  assign bus.inv   = inv_q;
`else
  assign bus.inv   = 1'b0;
`endif

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Self-checking bench for arm_imm_encoder: directed table, corner sequences, random vs model.
// Expectations follow ARM_IMM_ENC_INV_EN when the bench is built with it.
module tb_arm_imm_encoder;

  localparam int ROT_LIMIT = 16;
`ifdef ARM_IMM_ENC_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] value;
    bit          found;
    logic [11:0] enc;
    bit          inv;
    int          lat;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  arm_imm_encoder_if bus ();

  arm_imm_encoder #(.ROT_LIMIT(ROT_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] a, input int s);
    if (s == 0) return a;
    return (a >> s) | (a << (32 - s));
  endfunction

  // Reference: enumerate every (rot, imm8) pair the shifter can decode, lowest rot first.
  function automatic void model(input logic [31:0] v, output bit f, output logic [11:0] e,
                                output bit iv, output int lat);
    f = 1'b0; e = '0; iv = 1'b0; lat = 1 + ROT_LIMIT;
    for (int r = 0; r < ROT_LIMIT && !f; r++) begin
      for (int imm = 0; imm < 256 && !f; imm++) begin
        if (ror32(32'(imm), 2 * r) == v) begin
          f = 1'b1; e = {4'(r), 8'(imm)}; lat = 2 + r;
        end
      end
      for (int imm = 0; imm < 256 && !f && INV_EN; imm++) begin
        if (ror32(32'(imm), 2 * r) == ~v) begin
          f = 1'b1; e = {4'(r), 8'(imm)}; iv = 1'b1; lat = 2 + r;
        end
      end
    end
  endfunction

  // Start pulse in cycle k; n counts negedges after the sampling edge (n=1 is cycle k+1).
  task automatic run_vec(input string tag, input vec_t v, input bit extra_start);
    int n;
    bus.start = 1'b1;
    bus.value = v.value;
    @(negedge clk);
    bus.start = 1'b0;
    bus.value = $urandom;
    n = 1;
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    check({tag, " cleared"}, {19'd0, bus.found, bus.enc}, 32'd0);
    while (!bus.done && n < 40) begin
      bus.start = extra_start && (n == 3);
      if (bus.start) bus.value = $urandom;
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(v.lat));
    check({tag, " found"}, 32'(bus.found), 32'(v.found));
    check({tag, " enc"}, 32'(bus.enc), 32'(v.enc));
    check({tag, " inv"}, 32'(bus.inv), 32'(v.inv));
    repeat (3) @(negedge clk);
    check({tag, " hold"}, {18'd0, bus.done, bus.found, bus.enc}, {19'd0, v.found, v.enc});
  endtask

  vec_t vec [9];

  initial begin
    int   done_cnt;
    vec_t rv;
    logic [31:0] rval;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.value = '0;

    vec[0] = vec_t'{32'h000000FF, 1'b1, 12'h0FF, 1'b0, 2};
    vec[1] = vec_t'{32'hFF000000, 1'b1, 12'h4FF, 1'b0, 6};
    vec[2] = vec_t'{32'hF000000F, 1'b1, 12'h2FF, 1'b0, 4};
    vec[3] = vec_t'{32'h00000000, 1'b1, 12'h000, 1'b0, 2};
    vec[4] = vec_t'{32'h00000102, 1'b0, 12'h000, 1'b0, 17};
    vec[5] = INV_EN ? vec_t'{32'hFFFFFF00, 1'b1, 12'h0FF, 1'b1, 2}
                    : vec_t'{32'hFFFFFF00, 1'b0, 12'h000, 1'b0, 17};
    vec[6] = vec_t'{32'h000003FC, 1'b1, 12'hFFF, 1'b0, 17};
    vec[7] = vec_t'{32'h80000000, 1'b1, 12'h102, 1'b0, 3};
    vec[8] = INV_EN ? vec_t'{32'hFFFFFFFF, 1'b1, 12'h000, 1'b1, 2}
                    : vec_t'{32'hFFFFFFFF, 1'b0, 12'h000, 1'b0, 17};

    repeat (3) @(negedge clk);
    check("reset outputs", {16'd0, bus.busy, bus.done, bus.found, bus.inv, bus.enc}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vec[i], 1'b0);

    // Ignored second start, then reset mid-search: no done, outputs cleared.
    bus.start = 1'b1;
    bus.value = 32'h00000102;
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt = 0;
    for (int n = 1; n <= 25; n++) begin
      done_cnt += int'(bus.done);
      if (n == 6)
        check("reset mid-search", {16'd0, bus.busy, bus.done, bus.found, bus.inv, bus.enc}, 32'd0);
      bus.start = (n == 3);
      if (n == 3) bus.value = 32'h000000FF;
      reset = (n == 5);
      @(negedge clk);
    end
    check("no done after reset", 32'(done_cnt), 32'd0);
    check("no result after reset", {19'd0, bus.found, bus.enc}, 32'd0);
    run_vec("fresh after reset", vec[0], 1'b0);

    // Random stimulus checked against the enumeration model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rval = $urandom;
        1:       rval = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
        2:       rval = ~ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
        default: rval = 32'($urandom_range(0, 1023));
      endcase
      rv.value = rval;
      model(rval, rv.found, rv.enc, rv.inv, rv.lat);
      run_vec($sformatf("rand%0d v=%08h", i, rval), rv, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
